hex_ascii_streamer: RTL and testbench
=====================================

Name: hex_ascii_streamer

Overview:
Converts binary words (e.g. a 16-bit SPI-flash JEDEC/manufacturer ID) into a human-readable ASCII hex line for the UART TX byte stream. It sits between a word producer (flash ID reader, register snapshot) and the UART transmitter. It accepts one word per valid/ready handshake and emits an optional "0x" prefix, the hex digits MSB-nibble first, and an optional CR LF. Output is a byte stream with valid/ready/last.

Parameters:
DATA_WIDTH, 16, input word width; multiple of 4, range 4..64; N = DATA_WIDTH/4 hex digits
PREFIX_0X, 1, 1 = emit '0' 'x' (0x30 0x78) before the digits
UPPERCASE, 1, 1 = digits A-F are 0x41-0x46; 0 = a-f are 0x61-0x66
APPEND_CRLF, 1, 1 = emit 0x0D 0x0A after the digits

Ports:
clk  input  1  single clock for the whole block
rst  input  1  reset, synchronous, active-high
i_tready  output  1  block can accept a word
i_tvalid  input  1  input word valid
i_tdata  input  DATA_WIDTH  word to format
o_tready  input  1  downstream (UART TX) accepts the byte
o_tvalid  output  1  output byte valid
o_tdata  output  8  ASCII byte
o_tlast  output  1  high on the final byte of a line

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE, o_tvalid=0, o_tlast=0, o_tdata=0x00, i_tready=1 from the following cycle. Any in-progress line is dropped and never resumed.
- States: IDLE, PFX0, PFX1, DIGIT, CR, LF.
- IDLE: i_tready=1, o_tvalid=0. On i_tvalid&&i_tready, capture i_tdata into word_reg, set digit counter=N-1, go to PFX0 (PREFIX_0X=1) or DIGIT (PREFIX_0X=0).
- Non-IDLE: i_tready=0 and o_tvalid=1. Input is ignored and i_tdata is not sampled.
- A state advances only on o_tvalid&&o_tready. Otherwise o_tdata and o_tlast stay stable.
- PFX0 emits 0x30, then PFX1. PFX1 emits 0x78, then DIGIT.
- DIGIT emits the ASCII of word_reg[4*cnt+3:4*cnt]. Nibble 0-9 maps to 0x30+n. Nibble 10-15 maps to (UPPERCASE?0x41:0x61)+n-10. cnt decrements on each accept. At cnt==0 the next state is CR (APPEND_CRLF=1) or IDLE.
- CR emits 0x0D, then LF. LF emits 0x0A, then IDLE.
- o_tlast=1 only on the final byte of the line: LF if APPEND_CRLF=1, otherwise digit cnt==0.
- Line length L = 2*PREFIX_0X + N + 2*APPEND_CRLF. Default L=8.
- Latency: the first byte is valid on the cycle after the input handshake.
- Throughput: 1 byte/cycle while o_tready=1. After the last byte is accepted, IDLE lasts at least one cycle, so the back-to-back word period is L+1 cycles.
- Outputs are driven from registers or from state plus word_reg only. There is no combinational path from o_tready or i_* to any output.
- Producers without backpressure (single-cycle valid pulses) must pulse only while i_tready=1. A pulse while busy is lost, by design.
- Simultaneous rst and handshake: rst wins and nothing is captured.
- Parameter check: elaboration fails if DATA_WIDTH%4!=0 or DATA_WIDTH is outside 4..64.

Decomposition:
- Shared package holds the ASCII constants (ASC_0, ASC_X, ASC_CR, ASC_LF, ASC_UA, ASC_LA), the state encoding, and a function nibble_to_ascii(nibble, uppercase).
- No sub-module. The FSM plus the counter is small enough for a single module.

Test Plan:
- Default params, 0xEF17, o_tready=1: bytes 30 78 45 46 31 37 0D 0A in 8 consecutive cycles; o_tlast only on 0x0A; i_tready high again 1 cycle after the 0x0A accept.
- Same word, o_tready random at 50%: identical byte sequence; o_tdata/o_tlast stable across every stalled cycle; no byte dropped or duplicated.
- UPPERCASE=0, word 0xABCD: 30 78 61 62 63 64 0D 0A.
- DATA_WIDTH=8, PREFIX_0X=0, APPEND_CRLF=0, word 0x5A: bytes 35 41 only; o_tlast on 0x41.
- Reset mid-line: assert rst after 3 accepted bytes of 0x1234; o_tvalid=0 the next cycle. Then send 0x0000: full line 30 78 30 30 30 30 0D 0A, with no residue from the first word.
- Hold i_tvalid=1 with 0x0001 then 0x0002: i_tready low during each line. Exactly two lines, "0x0001\r\n" then "0x0002\r\n", 9-cycle period.

Source files
------------

// File: rtl/hex_ascii_streamer_pkg.sv
// rtl/hex_ascii_streamer_pkg.sv - ASCII constants, FSM encoding and nibble formatter for hex_ascii_streamer
package hex_ascii_streamer_pkg;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_X  = 8'h78;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PFX0,
        ST_PFX1,
        ST_DIGIT,
        ST_CR,
        ST_LF
    } state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic uppercase);
        if (nibble < 4'd10) begin
            return ASC_0 + {4'd0, nibble};
        end
        return (uppercase ? ASC_UA : ASC_LA) + {4'd0, nibble} - 8'd10;
    endfunction

endpackage

// File: rtl/hex_ascii_streamer.sv
// rtl/hex_ascii_streamer.sv - formats one input word per handshake into an ASCII hex line byte stream
module hex_ascii_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter bit PREFIX_0X   = 1'b1,
    parameter bit UPPERCASE   = 1'b1,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  i_tready,
    input  logic                  i_tvalid,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [7:0]            o_tdata,
    output logic                  o_tlast
);
    import hex_ascii_streamer_pkg::*;

    localparam int N     = DATA_WIDTH / 4;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int NSLOT = 1 << CNT_W;

    if ((DATA_WIDTH % 4) != 0 || DATA_WIDTH < 4 || DATA_WIDTH > 64) begin : g_bad_width
        $error("hex_ascii_streamer: DATA_WIDTH must be a multiple of 4 in 4..64");
    end

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_word;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            w_nibs [NSLOT];
    logic [3:0]            w_nibble;

    // Nibble table padded to a power of two so r_cnt indexes it at exact width.
    for (genvar g = 0; g < NSLOT; g++) begin : g_nib
        if (g < N) begin : g_real
            assign w_nibs[g] = r_word[4*g +: 4];
        end else begin : g_pad
            assign w_nibs[g] = 4'd0;
        end
    end

    assign w_nibble = w_nibs[r_cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_tvalid) begin
                r_word <= i_tdata;
                r_cnt  <= CNT_W'(N - 1);
            end else if (r_state == ST_DIGIT && o_tready) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs depend on state and captured word only; o_tready steers w_next alone.
    always_comb begin
        w_next   = r_state;
        i_tready = 1'b0;
        o_tvalid = 1'b1;
        o_tdata  = 8'h00;
        o_tlast  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                i_tready = 1'b1;
                o_tvalid = 1'b0;
                if (i_tvalid) begin
                    w_next = PREFIX_0X ? ST_PFX0 : ST_DIGIT;
                end
            end
            ST_PFX0: begin
                o_tdata = ASC_0;
                if (o_tready) begin
                    w_next = ST_PFX1;
                end
            end
            ST_PFX1: begin
                o_tdata = ASC_X;
                if (o_tready) begin
                    w_next = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                o_tdata = nibble_to_ascii(w_nibble, UPPERCASE);
                o_tlast = !APPEND_CRLF && (r_cnt == '0);
                if (o_tready && r_cnt == '0) begin
                    w_next = APPEND_CRLF ? ST_CR : ST_IDLE;
                end
            end
            ST_CR: begin
                o_tdata = ASC_CR;
                if (o_tready) begin
                    w_next = ST_LF;
                end
            end
            ST_LF: begin
                o_tdata = ASC_LF;
                o_tlast = 1'b1;
                if (o_tready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next   = ST_IDLE;
                o_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// tb/tb_hex_ascii_streamer.sv - scoreboard bench for hex_ascii_streamer across three parameter sets
module tb_hex_ascii_streamer;

    typedef logic [8:0] ent_t;

    logic clk = 1'b0;
    logic rst;
    logic o_tready;
    bit   rnd_mode = 1'b0;

    logic        a_itready, a_itvalid, a_otvalid, a_otlast;
    logic [15:0] a_itdata;
    logic [7:0]  a_otdata;
    logic        b_itready, b_itvalid, b_otvalid, b_otlast;
    logic [15:0] b_itdata;
    logic [7:0]  b_otdata;
    logic        c_itready, c_itvalid, c_otvalid, c_otlast;
    logic [7:0]  c_itdata;
    logic [7:0]  c_otdata;

    int nvec = 0;
    int nerr = 0;
    int lines_a = 0;
    ent_t qa[$];
    ent_t qb[$];
    ent_t qc[$];

    hex_ascii_streamer u_a (
        .clk(clk), .rst(rst), .i_tready(a_itready), .i_tvalid(a_itvalid), .i_tdata(a_itdata),
        .o_tready(o_tready), .o_tvalid(a_otvalid), .o_tdata(a_otdata), .o_tlast(a_otlast)
    );

    hex_ascii_streamer #(.UPPERCASE(1'b0)) u_b (
        .clk(clk), .rst(rst), .i_tready(b_itready), .i_tvalid(b_itvalid), .i_tdata(b_itdata),
        .o_tready(o_tready), .o_tvalid(b_otvalid), .o_tdata(b_otdata), .o_tlast(b_otlast)
    );

    hex_ascii_streamer #(.DATA_WIDTH(8), .PREFIX_0X(1'b0), .APPEND_CRLF(1'b0)) u_c (
        .clk(clk), .rst(rst), .i_tready(c_itready), .i_tvalid(c_itvalid), .i_tdata(c_itdata),
        .o_tready(o_tready), .o_tvalid(c_otvalid), .o_tdata(c_otdata), .o_tlast(c_otlast)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference line: prefix, hex digits from a lookup string, optional CR LF; last flag on final byte.
    task automatic push_line(input int which, input logic [63:0] w);
        int    dw;
        bit    pfx, up, crlf;
        string hex;
        ent_t  line[$];
        int    idx;
        case (which)
            0:       begin dw = 16; pfx = 1; up = 1; crlf = 1; end
            1:       begin dw = 16; pfx = 1; up = 0; crlf = 1; end
            default: begin dw = 8;  pfx = 0; up = 1; crlf = 0; end
        endcase
        if (up) hex = "0123456789ABCDEF";
        else    hex = "0123456789abcdef";
        if (pfx) begin
            line.push_back(9'h030);
            line.push_back(9'h078);
        end
        for (int i = dw / 4 - 1; i >= 0; i--) begin
            idx = int'((w >> (4 * i)) & 64'hF);
            line.push_back({1'b0, hex[idx]});
        end
        if (crlf) begin
            line.push_back(9'h00D);
            line.push_back(9'h00A);
        end
        line[line.size() - 1][8] = 1'b1;
        foreach (line[k]) begin
            case (which)
                0:       qa.push_back(line[k]);
                1:       qb.push_back(line[k]);
                default: qc.push_back(line[k]);
            endcase
        end
    endtask

    function automatic logic get_rdy(input int which);
        case (which)
            0:       return a_itready;
            1:       return b_itready;
            default: return c_itready;
        endcase
    endfunction

    function automatic logic get_vld(input int which);
        case (which)
            0:       return a_otvalid;
            1:       return b_otvalid;
            default: return c_otvalid;
        endcase
    endfunction

    task automatic drive(input int which, input logic v, input logic [63:0] w);
        case (which)
            0:       begin a_itvalid = v; a_itdata = w[15:0]; end
            1:       begin b_itvalid = v; b_itdata = w[15:0]; end
            default: begin c_itvalid = v; c_itdata = w[7:0]; end
        endcase
    endtask

    task automatic wait_idle(input int which);
        int n = 0;
        while (!get_rdy(which) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 300), 64'd0);
    endtask

    // One-word send; exp_period > 0 also checks first-byte latency and handshake-to-ready period.
    task automatic send(input int which, input logic [63:0] w, input int exp_period);
        int n;
        wait_idle(which);
        drive(which, 1'b1, w);
        push_line(which, w);
        @(negedge clk);
        drive(which, 1'b0, w);
        n = 1;
        if (exp_period > 0) chk("first_latency", 64'(get_vld(which)), 64'd1);
        while (!get_rdy(which) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_period > 0) chk("period", 64'(n), 64'(exp_period));
        else                chk("line_done", 64'(get_rdy(which)), 64'd1);
    endtask

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rnd_mode ? 1'($urandom % 2) : 1'b1;
        end
    end

    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid", 64'(a_otvalid), 64'd1);
            chk("stall_data", 64'(a_otdata), 64'(prev_data));
            chk("stall_last", 64'(a_otlast), 64'(prev_last));
        end
        chk("a_ready_vs_valid", 64'(a_itready), 64'(!a_otvalid));
        if (a_otvalid && o_tready) begin
            if (qa.size() == 0) chk("a_extra_byte", 64'({a_otlast, a_otdata}), 64'h1FF);
            else                chk("a_byte", 64'({a_otlast, a_otdata}), 64'(qa.pop_front()));
            if (a_otlast) lines_a++;
        end
        prev_stall = a_otvalid && !o_tready;
        prev_data  = a_otdata;
        prev_last  = a_otlast;
    end

    always @(negedge clk) begin
        if (b_otvalid && o_tready) begin
            if (qb.size() == 0) chk("b_extra_byte", 64'({b_otlast, b_otdata}), 64'h1FF);
            else                chk("b_byte", 64'({b_otlast, b_otdata}), 64'(qb.pop_front()));
        end
        if (c_otvalid && o_tready) begin
            if (qc.size() == 0) chk("c_extra_byte", 64'({c_otlast, c_otdata}), 64'h1FF);
            else                chk("c_byte", 64'({c_otlast, c_otdata}), 64'(qc.pop_front()));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        int l0;
        rst = 1'b1;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("rst_a_tvalid", 64'(a_otvalid), 64'd0);
        chk("rst_a_tdata", 64'(a_otdata), 64'd0);
        chk("rst_a_tlast", 64'(a_otlast), 64'd0);
        chk("rst_a_itready", 64'(a_itready), 64'd1);
        chk("rst_b_itready", 64'(b_itready), 64'd1);
        chk("rst_c_tvalid", 64'(c_otvalid), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(0, 64'hEF17, 9);

        rnd_mode = 1'b1;
        repeat (3) send(0, 64'hEF17, 0);
        repeat (12) send(0, 64'($urandom), 0);
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);

        send(1, 64'hABCD, 9);
        repeat (6) send(1, 64'($urandom), 9);
        send(2, 64'h5A, 3);
        repeat (6) send(2, 64'($urandom), 3);

        // Reset after three bytes of 0x1234: nothing more of that line may appear.
        wait_idle(0);
        drive(0, 1'b1, 64'h1234);
        qa.push_back(9'h030);
        qa.push_back(9'h078);
        qa.push_back(9'h031);
        @(negedge clk);
        drive(0, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_tvalid", 64'(a_otvalid), 64'd0);
        chk("rst_mid_queue", 64'(qa.size()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        send(0, 64'h0000, 9);

        // Reset coinciding with a handshake must capture nothing.
        rst = 1'b1;
        drive(0, 1'b1, 64'hFFFF);
        @(negedge clk);
        chk("rst_hs_tvalid", 64'(a_otvalid), 64'd0);
        drive(0, 1'b0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hs_idle", 64'(a_otvalid), 64'd0);

        // i_tvalid held high across two words: back-to-back lines at L+1 period.
        wait_idle(0);
        l0 = lines_a;
        drive(0, 1'b1, 64'h0001);
        push_line(0, 64'h0001);
        @(negedge clk);
        drive(0, 1'b1, 64'h0002);
        push_line(0, 64'h0002);
        n = 1;
        while (!a_itready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold_period", 64'(n), 64'd9);
        @(negedge clk);
        drive(0, 1'b0, 0);
        n = 1;
        while (!a_itready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("hold_period2", 64'(n), 64'd9);
        chk("hold_lines", 64'(lines_a - l0), 64'd2);

        repeat (4) @(negedge clk);
        chk("drain_a", 64'(qa.size()), 64'd0);
        chk("drain_b", 64'(qb.size()), 64'd0);
        chk("drain_c", 64'(qc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
